ip_tile_seq_alu: RTL

//  Second-generation IP tile. Same CSR/data-register contract as the first tile, plus a command decoder.

---
 rtl/ip_tile_seq_alu.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/ip_tile_seq_alu.sv
// ip_tile_seq_alu
// Sequential ALU tile with a small command decoder. It sits between the CSR
// bridge and the data registers A/B/C. It accepts one command at a time from
// IDLE. It runs add/sub in one EXEC cycle and multiply/MAC as a W-step
// shift-add. It reports completion via csr_out/csr_out_we.
//
// Handshake: csr_in_re is a single-cycle strobe with no back-pressure. A
// strobe sampled in IDLE is accepted. A strobe sampled in any other state is
// discarded and sets the sticky dropped flag. csr_out_we pulses for exactly
// one cycle per accepted command, and never in consecutive cycles.
//
// Optional feature: define IP_TILE_SAT_EN to saturate overflowing results
// instead of wrapping. Timing and status bits are the same in both builds.
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   csr_in      command: [2:0] op, [3] signed
//   csr_in_re   command strobe (csr_in, data_reg_a/b valid this cycle)
//   data_reg_a  operand A
//   data_reg_b  operand B
//   csr_out     status: [0] done [1] busy [2] ovf [3] illegal [4] dropped
//               [7:5] last op [15:8] op count
//   csr_out_we  one-cycle completion pulse
//   data_reg_c  result register
module ip_tile_seq_alu #(
    parameter int CSR_IN_WIDTH  = 16,
    parameter int CSR_OUT_WIDTH = 16,
    parameter int REG_WIDTH     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CSR_IN_WIDTH-1:0]  csr_in,
    input  logic                     csr_in_re,
    input  logic [REG_WIDTH-1:0]     data_reg_a,
    input  logic [REG_WIDTH-1:0]     data_reg_b,
    output logic [CSR_OUT_WIDTH-1:0] csr_out,
    output logic                     csr_out_we,
    output logic [REG_WIDTH-1:0]     data_reg_c
);
    localparam int W  = REG_WIDTH;
    localparam int CW = $clog2(W + 1);

    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_MUL = 3'd3;
    localparam logic [2:0] OP_MAC = 3'd4;
    localparam logic [2:0] OP_CLR = 3'd5;

    typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;
    state_t state;

    logic [2:0]     op_r;
    logic           sgn_r;
    logic [W-1:0]   a_r;
    logic [W-1:0]   b_r;      // shifted right one bit per multiply step
    logic [2*W-1:0] mcand;    // A, shifted left one bit per multiply step
    logic [2*W-1:0] prod;
    logic [CW-1:0]  step;
    logic [W-1:0]   acc;

    logic       done, busy, ovf, illegal, dropped;
    logic [2:0] last_op;
    logic [7:0] count;

    // Bits of csr_in above the signed bit carry no meaning.
    logic unused_csr_bits;
    assign unused_csr_bits = ^csr_in[CSR_IN_WIDTH-1:4];

    // Single-cycle op results, consumed in EXEC.
    logic [W:0]   sum, dif;
    logic [W-1:0] exec_c, exec_acc;
    logic         exec_ovf, exec_ill;
    // Multiply/MAC results, consumed on the final MUL edge.
    logic [W:0]   mac_sum;
    logic [W-1:0] mul_res;
    logic         mul_ovf;

    always_comb begin
        sum      = {1'b0, a_r} + {1'b0, b_r};
        dif      = {1'b0, a_r} - {1'b0, b_r};
        exec_c   = data_reg_c;
        exec_acc = acc;
        exec_ovf = 1'b0;
        exec_ill = 1'b0;
        case (op_r)
            OP_ADD: begin
                exec_c   = sum[W-1:0];
                exec_ovf = sgn_r ? ((a_r[W-1] == b_r[W-1]) && (sum[W-1] != a_r[W-1]))
                                 : sum[W];
`ifdef IP_TILE_SAT_EN
                // Signed overflow direction follows the sign of A.
                if (exec_ovf)
                    exec_c = sgn_r ? (a_r[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}})
                                   : {W{1'b1}};
`endif
            end
            OP_SUB: begin
                exec_c   = dif[W-1:0];
                exec_ovf = sgn_r ? ((a_r[W-1] != b_r[W-1]) && (dif[W-1] != a_r[W-1]))
                                 : dif[W];
`ifdef IP_TILE_SAT_EN
                if (exec_ovf)
                    exec_c = sgn_r ? (a_r[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}})
                                   : {W{1'b0}};
`endif
            end
            OP_CLR: begin
                exec_c   = '0;
                exec_acc = '0;
            end
            3'd6, 3'd7: exec_ill = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        mac_sum = {1'b0, acc} + {1'b0, prod[W-1:0]};
        if (op_r == OP_MAC) begin
            mul_res = mac_sum[W-1:0];
            mul_ovf = (|prod[2*W-1:W]) | mac_sum[W];
        end else begin
            mul_res = prod[W-1:0];
            mul_ovf = |prod[2*W-1:W];
        end
`ifdef IP_TILE_SAT_EN
        if (mul_ovf)
            mul_res = {W{1'b1}};
`endif
    end

    always_comb begin
        csr_out       = '0;
        csr_out[15:0] = {count, last_op, dropped, illegal, ovf, busy, done};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            op_r       <= '0;
            sgn_r      <= 1'b0;
            a_r        <= '0;
            b_r        <= '0;
            mcand      <= '0;
            prod       <= '0;
            step       <= '0;
            acc        <= '0;
            data_reg_c <= '0;
            csr_out_we <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
            ovf        <= 1'b0;
            illegal    <= 1'b0;
            dropped    <= 1'b0;
            last_op    <= '0;
            count      <= '0;
        end else begin
            csr_out_we <= 1'b0;
            if (csr_in_re && state != IDLE)
                dropped <= 1'b1;
            case (state)
                IDLE: begin
                    if (csr_in_re) begin
                        op_r    <= csr_in[2:0];
                        sgn_r   <= csr_in[3];
                        a_r     <= data_reg_a;
                        b_r     <= data_reg_b;
                        mcand   <= {{W{1'b0}}, data_reg_a};
                        prod    <= '0;
                        step    <= '0;
                        done    <= 1'b0;
                        ovf     <= 1'b0;
                        illegal <= 1'b0;
                        dropped <= 1'b0;
                        busy    <= 1'b1;
                        state   <= (csr_in[2:0] == OP_MUL || csr_in[2:0] == OP_MAC) ? MUL : EXEC;
                    end
                end
                EXEC: begin
                    data_reg_c <= exec_c;
                    acc        <= exec_acc;
                    ovf        <= exec_ovf;
                    illegal    <= exec_ill;
                    state      <= DONE;
                end
                MUL: begin
                    // W shift-add steps, then one edge to commit the result.
                    if (step == CW'(W)) begin
                        data_reg_c <= mul_res;
                        ovf        <= mul_ovf;
                        if (op_r == OP_MAC)
                            acc <= mul_res;
                        state <= DONE;
                    end else begin
                        if (b_r[0])
                            prod <= prod + mcand;
                        mcand <= mcand << 1;
                        b_r   <= b_r >> 1;
                        step  <= step + 1'b1;
                    end
                end
                DONE: begin
                    csr_out_we <= 1'b1;
                    done       <= 1'b1;
                    busy       <= 1'b0;
                    last_op    <= op_r;
                    count      <= count + 8'd1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
